// File: rtl/router_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : router_pkg                                                   |
// | Description : Shared router definitions: packet width, transmit arbiter    |
// |               FSM states and the default transmitter accept timeout.       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package router_pkg;

  // Width of one router packet as carried to the serial transmitter.
  localparam int PKT_W = 55;

  // Default number of SEND cycles allowed before the transmitter must accept.
  localparam int ACC_TIMEOUT_DEF = 15;

  // Transmit arbiter states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    XMIT = 2'd2
  } arb_state_e;

endpackage : router_pkg
`default_nettype wire

// File: rtl/tx_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tx_arbiter_if                                                |
// | Description : Bundle between router queues / transmitter and tx_arbiter.   |
// |   req, req_data, port_en : per-port requests, packets and enables         |
// |   ack                    : one-hot packet-latched pulse back to the ports |
// |   TX_Data, TX_Data_Valid : packet and start request to the transmitter    |
// |   TX_Ready               : transmitter idle / will accept                 |
// |   busy, gnt_idx, tx_err  : arbiter status                                 |
// |   modport slave  : arbiter side;  modport master : queues + transmitter   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface tx_arbiter_if
  import router_pkg::*;
#(
  parameter int N = 4
) ();

  localparam int IDX_W = $clog2(N);

  logic [N-1:0]       req;
  logic [N*PKT_W-1:0] req_data;
  logic [N-1:0]       port_en;
  logic [N-1:0]       ack;
  logic [PKT_W-1:0]   TX_Data;
  logic               TX_Data_Valid;
  logic               TX_Ready;
  logic               busy;
  logic [IDX_W-1:0]   gnt_idx;
  logic               tx_err;

  modport slave (
    input  req, req_data, port_en, TX_Ready,
    output ack, TX_Data, TX_Data_Valid, busy, gnt_idx, tx_err
  );

  modport master (
    output req, req_data, port_en, TX_Ready,
    input  ack, TX_Data, TX_Data_Valid, busy, gnt_idx, tx_err
  );

endinterface : tx_arbiter_if
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_picker                                                    |
// | Description : Combinational round-robin pick. Returns the first set bit   |
// |               of elig at or above ptr, wrapping modulo N.                  |
// |   elig  : eligible requesters                                            |
// |   ptr   : highest-priority index                                         |
// |   found : at least one requester eligible                                |
// |   idx   : chosen index (0 when nothing is found)                         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  wire logic [N-1:0]     elig,
  input  wire logic [IDX_W-1:0] ptr,
  output logic                  found,
  output logic [IDX_W-1:0]      idx
);

  // One extra bit so ptr + offset never overflows before the modulo step.
  localparam logic [IDX_W:0] c_N = (IDX_W+1)'(N);

  logic [IDX_W:0] w_pos;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    w_pos = '0;
    for (int i = 0; i < N; i++) begin
      w_pos = {1'b0, ptr} + (IDX_W+1)'(i);
      if (w_pos >= c_N) begin
        w_pos = w_pos - c_N;
      end
      if (!found && elig[w_pos[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = w_pos[IDX_W-1:0];
      end
    end
  end

endmodule : rr_picker
`default_nettype wire

// File: rtl/tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tx_arbiter                                                   |
// | Description : Round-robin arbiter sharing one serial transmitter among N  |
// |               router output queues. Latches the winner's packet, drives   |
// |               the TX handshake until the frame ends, then re-arbitrates.  |
// |   Clk_S : clock (rising edge)                                            |
// |   Rst_n : asynchronous active-low reset                                  |
// |   bus   : tx_arbiter_if.slave (requests, packets, TX handshake, status)  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tx_arbiter
  import router_pkg::*;
#(
  parameter int N           = 4,
  parameter int IDX_W       = $clog2(N),
  parameter int ACC_TIMEOUT = ACC_TIMEOUT_DEF
) (
  input  wire logic   Clk_S,
  input  wire logic   Rst_n,
  tx_arbiter_if.slave bus
);

  localparam int             c_CNT_W    = 8;
  localparam logic [c_CNT_W-1:0] c_TO_LAST  = c_CNT_W'(ACC_TIMEOUT - 1);
  localparam logic [IDX_W-1:0]   c_LAST_IDX = IDX_W'(N - 1);

  arb_state_e           state_q, state_d;
  logic [N-1:0]         ack_q, ack_d;
  logic [PKT_W-1:0]     data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic [IDX_W-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic                 err_q, err_d;
  logic [c_CNT_W-1:0]   cnt_q, cnt_d;

  logic [N-1:0]         w_elig;
  logic                 w_found;
  logic [IDX_W-1:0]     w_pick;
  logic [PKT_W-1:0]     w_pick_data;
  logic [IDX_W-1:0]     w_gnt_next;

  assign w_elig = bus.req & bus.port_en;

  rr_picker #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_picker (
    .elig  (w_elig),
    .ptr   (ptr_q),
    .found (w_found),
    .idx   (w_pick)
  );

  // Packet of the current round-robin winner.
  always_comb begin
    w_pick_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_pick == IDX_W'(i)) begin
        w_pick_data = bus.req_data[i*PKT_W +: PKT_W];
      end
    end
  end

  // Priority moves to the port after the one just served.
  assign w_gnt_next = (gnt_q == c_LAST_IDX) ? '0 : gnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    ack_d   = '0;
    data_d  = data_q;
    valid_d = valid_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        // Granting only while the transmitter is idle keeps TX_Data stable
        // for the whole frame.
        if (bus.TX_Ready && w_found) begin
          data_d        = w_pick_data;
          gnt_d         = w_pick;
          ack_d[w_pick] = 1'b1;
          valid_d       = 1'b1;
          cnt_d         = '0;
          state_d       = SEND;
        end
      end
      SEND: begin
        cnt_d = cnt_q + 1'b1;
        if (!bus.TX_Ready) begin
          valid_d = 1'b0;
          state_d = XMIT;
        end else if (cnt_q == c_TO_LAST) begin
          // Transmitter never took the packet; it was already acked, so it
          // is dropped and the fault is remembered until reset.
          valid_d = 1'b0;
          err_d   = 1'b1;
          ptr_d   = w_gnt_next;
          state_d = IDLE;
        end
      end
      XMIT: begin
        if (bus.TX_Ready) begin
          ptr_d   = w_gnt_next;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk_S or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      ack_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      gnt_q   <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.ack           = ack_q;
  assign bus.TX_Data       = data_q;
  assign bus.TX_Data_Valid = valid_q;
  assign bus.busy          = busy_q;
  assign bus.gnt_idx       = gnt_q;
  assign bus.tx_err        = err_q;

endmodule : tx_arbiter
`default_nettype wire

// File: doc/tx_arbiter.md
# tx_arbiter

Round-robin arbiter that shares the single serial transmitter among N router output queues. It picks one enabled requester and latches that requester's 55-bit packet. It then drives the transmitter's TX_Data/TX_Data_Valid/TX_Ready handshake until the serial frame completes, and only then arbitrates again. It sits between the router queue logic and the transmitter, in the Clk_S domain.

## Interface
- N, 4: number of requesters, legal range 2..8.
- IDX_W, $clog2(N): width of the grant index.
- ACC_TIMEOUT, 15: max cycles in SEND waiting for TX_Ready to fall. Legal range 1..255.
- Clk_S  in  1  sole clock, rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- req  in  N  per-port request. The port holds req and its data until it sees ack.
- req_data  in  N*55  packets, port i at bits [i*55 +: 55].
- port_en  in  N  per-port enable. A disabled port is never granted.
- ack  out  N  one-hot, 1-cycle pulse: that port's packet has been latched.
- TX_Data  out  55  packet to the transmitter.
- TX_Data_Valid  out  1  start request to the transmitter.
- TX_Ready  in  1  transmitter is idle and will accept.
- busy  out  1  high in every state except IDLE.
- gnt_idx  out  IDX_W  index of the last granted port.
- tx_err  out  1  sticky accept-timeout flag. Cleared only by reset.

## Operation
- Reset values: state=IDLE, ack=0, TX_Data=0, TX_Data_Valid=0, busy=0, gnt_idx=0, tx_err=0, priority pointer ptr=0, timeout counter=0. All outputs are registered.
- Eligible ports: elig = req & port_en.
- IDLE:
  - If TX_Ready=1 and elig≠0, pick the first set bit of elig, searching from ptr upward and wrapping modulo N.
  - In that cycle: latch req_data of the winner into TX_Data, gnt_idx=winner, pulse ack[winner], set TX_Data_Valid=1, counter=0, go to SEND.
  - If TX_Ready=0 or elig=0, stay in IDLE.
- SEND:
  - TX_Data_Valid=1 and TX_Data is held. The counter increments each cycle.
  - If TX_Ready=0: drop TX_Data_Valid, go to XMIT.
  - Else if counter reaches ACC_TIMEOUT-1: drop TX_Data_Valid, set tx_err, set ptr=gnt_idx+1 mod N, go to IDLE. The packet is lost; it has already been acked.
- XMIT:
  - TX_Data_Valid=0 and TX_Data is held stable.
  - When TX_Ready=1 (frame done, transmitter ready again): set ptr=gnt_idx+1 mod N, go to IDLE.
- ptr wrap: N-1 wraps to 0.
- No acceptance until transmitter is idle: IDLE does not grant while TX_Ready=0. After reset, TX_Ready stays low until the transmitter sees TX_Data_Valid=0, which is already guaranteed.
- Simultaneous requests: only the round-robin winner is acked. Losers keep req asserted and are served in later rounds.
- req dropped after ack has no effect. The packet is already latched.
- port_en cleared mid-frame only affects future arbitration.
- Asynchronous reset mid-frame returns to reset values immediately. The transmitter is reset by the same Rst_n.

## Timing
- Grant: ack, TX_Data and TX_Data_Valid all appear at the clock edge that samples TX_Ready=1 with elig≠0 in IDLE.
- The transmitter's TX_Ready falls 2 cycles after TX_Data_Valid rises. SEND therefore normally lasts 2 cycles; ACC_TIMEOUT must be ≥3 for normal operation.
- Re-arbitration: the earliest next grant is 1 cycle after the XMIT→IDLE transition.
- Throughput: one packet per transmitter frame plus 2 cycles.
- ack is never asserted for more than one cycle, and never for two ports at once.

## Structure
- Shared package router_pkg holds:
  - PKT_W=55.
  - State enum {IDLE, SEND, XMIT}.
  - Default ACC_TIMEOUT.
- Sub-module rr_picker: combinational round-robin pick.
  - Inputs: elig[N], ptr[IDX_W].
  - Outputs: found, idx[IDX_W].
  - Reusable by other router arbiters.
- tx_arbiter contains the FSM, data latch, counter and ptr register.

## Test plan
- Single port: req=4'b0100 with data 55'h0AB_CDEF_0123, transmitter model frame 60 cycles → ack=4'b0100 for 1 cycle, TX_Data equals the data, Valid high 2 cycles, busy low after the frame, gnt_idx=2.
- Fairness: all 4 ports request continuously → grant order 0,1,2,3,0,1; each port gets exactly one ack per 4 frames.
- Wrap and enable: ptr=3, req=4'b1001, port_en=4'b0111 → port 0 granted, port 3 never acked.
- Timeout: transmitter held with TX_Ready=1 and ignoring Valid, ACC_TIMEOUT=5 → Valid drops after 5 cycles, tx_err=1 and stays set, FSM returns to IDLE, ptr advances.
- Startup: TX_Ready=0 after reset with req=4'b0001 → no ack until TX_Ready=1, then ack[0] pulses at that edge.
- Reset in XMIT mid-frame → all outputs 0 next sample, tx_err=0, the next grant starts from port 0.
